// File: rtl/ls166_pkg.sv
// Shared TTL shift-register definitions: operating modes and register width.
// Kept generic so ls165/ls299 models can reuse them.
package ls166_pkg;

  localparam int unsigned LS166_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_HOLD,
    MODE_LOAD,
    MODE_SHIFT
  } ttl_mode_e;

  // Clocked mode for a load/shift register; clear is handled outside as it is asynchronous.
  function automatic ttl_mode_e decode_mode(input logic clk_inh, input logic sh_ld);
    if (clk_inh) begin
      return MODE_HOLD;
    end else if (!sh_ld) begin
      return MODE_LOAD;
    end else begin
      return MODE_SHIFT;
    end
  endfunction

endpackage

// File: rtl/ls166.sv
// SN74LS166 8-bit parallel-in/serial-out shift register with clock inhibit and
// asynchronous active-low clear. q[0] is stage QA, q[7] is stage QH.
module ls166
  import ls166_pkg::*;
(
  input  logic _CLK,
  input  logic _CLR,
  input  logic _CLK_INH,
  input  logic _SH_LD,
  input  logic _SER,
  input  logic _A,
  input  logic _B,
  input  logic _C,
  input  logic _D,
  input  logic _E,
  input  logic _F,
  input  logic _G,
  input  logic _H,
  output logic _QH
);

  logic [LS166_WIDTH-1:0] q_q;
  logic [LS166_WIDTH-1:0] q_d;
  logic [LS166_WIDTH-1:0] par;
  ttl_mode_e              mode;

  // _A lands in the first stage, _H in the last.
  assign par = {_H, _G, _F, _E, _D, _C, _B, _A};

  always_comb begin
    mode = decode_mode(_CLK_INH, _SH_LD);
    q_d  = q_q;
    unique case (mode)
      MODE_HOLD:  q_d = q_q;
      MODE_LOAD:  q_d = par;
      MODE_SHIFT: q_d = {q_q[LS166_WIDTH-2:0], _SER};
      default:    q_d = q_q;
    endcase
  end

  always_ff @(posedge _CLK or negedge _CLR) begin
    if (!_CLR) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign _QH = q_q[LS166_WIDTH-1];

endmodule
